// File: rtl/adc_arb_pkg.sv
// adc_arb_pkg: FSM state encoding and width default shared by the adc_arbiter files
package adc_arb_pkg;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DELIVER = 2'd2} state_t;
endpackage

// File: rtl/adc_arbiter_if.sv
// adc_arbiter_if: requester and shared-ADC signals; slave is the arbiter's view, master the environment's
interface adc_arbiter_if import adc_arb_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
);
    logic              req0, req1, rdy0, rdy1;
    logic [DATA_W-1:0] dat0, dat1;
    logic              adc_req, adc_rdy;
    logic [DATA_W-1:0] adc_dat;
    logic [1:0]        grant;
    logic              timeout_err;
    modport slave (
        input  req0, req1, adc_rdy, adc_dat,
        output rdy0, rdy1, dat0, dat1, adc_req, grant, timeout_err
    );
    modport master (
        output req0, req1, adc_rdy, adc_dat,
        input  rdy0, rdy1, dat0, dat1, adc_req, grant, timeout_err
    );
endinterface

// File: rtl/adc_rr_pick.sv
// adc_rr_pick: combinational two-way round-robin pick, one-hot out
module adc_rr_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] pick
);
    // last names the most recently granted channel; a tie goes to the other one
    assign pick = {req1 & (~req0 | ~last), req0 & (~req1 | last)};
endmodule

// File: rtl/adc_arbiter.sv
// adc_arbiter: round-robin sharing of one ADC between two requesters.
// Define ADC_ARB_TIMEOUT_EN to add a CONV watchdog with a sticky timeout_err.
module adc_arbiter import adc_arb_pkg::*; #(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    adc_arbiter_if.slave bus
);
    state_t            state;
    logic              last, drop, held;
    logic [1:0]        pick;
    logic [DATA_W-1:0] sample;

    assign sample = bus.adc_dat;
    assign held   = |(bus.grant & {bus.req1, bus.req0});

    adc_rr_pick u_pick (.req0(bus.req0), .req1(bus.req1), .last(last), .pick(pick));

`ifdef ADC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            drop        <= 1'b0;
            bus.adc_req <= 1'b0;
            bus.grant   <= 2'b00;
            bus.rdy0    <= 1'b0;
            bus.rdy1    <= 1'b0;
            bus.dat0    <= '0;
            bus.dat1    <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
            wd              <= '0;
            bus.timeout_err <= 1'b0;
`endif
        end else begin
            bus.rdy0 <= 1'b0;
            bus.rdy1 <= 1'b0;
            case (state)
                IDLE: if (|pick) begin
                    state       <= CONV;
                    bus.grant   <= pick;
                    last        <= pick[1];
                    bus.adc_req <= 1'b1;
                    drop        <= 1'b0;
                end
                CONV: if (bus.adc_rdy) begin
                    bus.adc_req <= 1'b0;
`ifdef ADC_ARB_TIMEOUT_EN
                    wd          <= '0;
`endif
                    // a requester that let go at any point in CONV forfeits the sample
                    if (drop || !held) begin
                        state     <= IDLE;
                        bus.grant <= 2'b00;
                    end else begin
                        state    <= DELIVER;
                        bus.rdy0 <= bus.grant[0];
                        bus.rdy1 <= bus.grant[1];
                        if (bus.grant[0]) bus.dat0 <= sample;
                        if (bus.grant[1]) bus.dat1 <= sample;
                    end
                end else begin
                    drop <= drop | ~held;
`ifdef ADC_ARB_TIMEOUT_EN
                    if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state           <= IDLE;
                        bus.adc_req     <= 1'b0;
                        bus.grant       <= 2'b00;
                        bus.timeout_err <= 1'b1;
                        wd              <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                default: begin
                    state     <= IDLE;
                    bus.grant <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_arbiter.sv
// tb_adc_arbiter: random and directed transactions against a round-robin reference model,
// deliveries checked by a scoreboard monitor (ADC_ARB_TIMEOUT_EN enables the watchdog case).
module tb_adc_arbiter;
    localparam int TO = 4;
    typedef struct { int ch; int d; } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0, n_fail = 0;
    exp_t sb[$];
    bit   r0, r1;
    int   last_m = 1, m_dat0 = 0, m_dat1 = 0;

    adc_arbiter_if #(.DATA_W(8)) bus ();
    adc_arbiter #(.DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // round robin from the rule itself: lone request wins, a tie goes away from last winner
    function automatic int model_pick(input bit a, input bit b, input int last);
        if (a && b) return (last == 0) ? 1 : 0;
        return a ? 0 : 1;
    endfunction

    always @(negedge clk) begin
        if (reset && (bus.rdy0 || bus.rdy1)) begin
            exp_t e;
            check("rdy_onehot", int'(bus.rdy0 & bus.rdy1), 0);
            if (sb.size() == 0) begin
                check("spurious_rdy", int'({bus.rdy1, bus.rdy0}), 0);
            end else begin
                e = sb.pop_front();
                check("rdy_chan", int'(bus.rdy1), e.ch);
                if (e.ch == 1) m_dat1 = e.d; else m_dat0 = e.d;
                check("rdy_dat0", int'(bus.dat0), m_dat0);
                check("rdy_dat1", int'(bus.dat1), m_dat1);
            end
        end
    end

    task automatic drive_req;
        bus.req0 = r0;
        bus.req1 = r1;
    endtask

    task automatic do_reset;
        r0 = 0; r1 = 0; drive_req();
        bus.adc_rdy = 0;
        reset = 0;
        #3;
        check("rst_adc_req", int'(bus.adc_req), 0);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_rdy", int'({bus.rdy1, bus.rdy0}), 0);
        check("rst_dat0", int'(bus.dat0), 0);
        check("rst_dat1", int'(bus.dat1), 0);
        check("rst_timeout", int'(bus.timeout_err), 0);
        sb.delete(); last_m = 1; m_dat0 = 0; m_dat1 = 0;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic xact(input bit s0, input bit s1, input int d, input int dly,
                        input bit ab, input int ab_at, input bit keep, input bit stray);
        int ch, n;
        logic [1:0] eg;
        r0 |= s0; r1 |= s1;
        drive_req();
        if (!(r0 || r1)) return;
        ch = model_pick(r0, r1, last_m);
        last_m = ch;
        eg = (ch == 1) ? 2'b10 : 2'b01;
        bus.adc_rdy = stray;
        bus.adc_dat = 8'($urandom);
        tick();
        bus.adc_rdy = 0;
        n = 0;
        while (!bus.adc_req && n < 8) begin tick(); n++; end
        check("adc_req_lat", n, 0);
        check("grant_conv", int'(bus.grant), int'(eg));
        if (!bus.adc_req) return;
        for (int i = 0; i <= dly; i++) begin
            if (ab && i == ab_at) begin
                if (ch == 1) r1 = 0; else r0 = 0;
                drive_req();
            end
            bus.adc_rdy = (i == dly);
            if (i == dly) begin
                bus.adc_dat = 8'(d);
                if (!ab) sb.push_back('{ch, d});
            end
            tick();
        end
        bus.adc_rdy = 0;
        check("adc_req_done", int'(bus.adc_req), 0);
        if (ab) begin
            check("grant_abort", int'(bus.grant), 0);
        end else begin
            check("grant_deliver", int'(bus.grant), int'(eg));
            if (!keep) begin
                if (ch == 1) r1 = 0; else r0 = 0;
                drive_req();
            end
            tick();
            check("grant_idle", int'(bus.grant), 0);
        end
        check("sb_empty", sb.size(), 0);
        check("dat0_hold", int'(bus.dat0), m_dat0);
        check("dat1_hold", int'(bus.dat1), m_dat1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.adc_rdy = 0; bus.adc_dat = 0;
        do_reset();
        xact(1, 0, 8'hD5, 1, 0, 0, 0, 0);
        do_reset();
        xact(1, 1, 8'h0A, 1, 0, 0, 0, 0);
        xact(0, 0, 8'h99, 0, 0, 0, 0, 0);
        xact(0, 1, 8'h9B, 2, 1, 1, 0, 0);
        xact(0, 1, 8'h5C, 3, 1, 3, 0, 1);
        // a held request loses to the other channel, then is served again
        xact(1, 1, 8'h11, 0, 0, 0, 1, 0);
        xact(0, 0, 8'h22, 1, 0, 0, 1, 0);
        xact(0, 0, 8'h33, 2, 0, 0, 0, 0);
        xact(0, 0, 8'h44, 0, 0, 0, 0, 0);
        repeat (60) begin
            bit s0, s1;
            int dly;
            s0 = 1'($urandom); s1 = 1'($urandom);
            if (!(s0 || s1 || r0 || r1)) s0 = 1;
            dly = $urandom_range(0, 3);
            xact(s0, s1, $urandom_range(0, 255), dly, ($urandom % 5) == 0,
                 $urandom_range(0, dly), ($urandom % 4) == 0, ($urandom % 4) == 0);
        end
        bus.adc_rdy = 1;
        r0 = 0; r1 = 0; drive_req();
        if (!(bus.grant == 0)) tick();
        tick(); tick();
        bus.adc_rdy = 0;
        check("stray_idle_adc_req", int'(bus.adc_req), 0);
`ifdef ADC_ARB_TIMEOUT_EN
        begin
            int n;
            do_reset();
            r0 = 1; drive_req();
            tick();
            n = 0;
            while (bus.adc_req && n < 20) begin tick(); n++; end
            check("timeout_cycles", n, TO);
            check("timeout_err_set", int'(bus.timeout_err), 1);
            check("timeout_grant", int'(bus.grant), 0);
            check("timeout_rdy", int'({bus.rdy1, bus.rdy0}), 0);
            last_m = 0;
            r0 = 0; drive_req();
            xact(0, 1, 8'h77, 1, 0, 0, 0, 0);
            check("timeout_err_sticky", int'(bus.timeout_err), 1);
        end
`else
        check("timeout_err_tied", int'(bus.timeout_err), 0);
`endif
        do_reset();
        r0 = 1; r1 = 1; drive_req();
        tick();
        check("pre_rst_adc_req", int'(bus.adc_req), 1);
        #2;
        bus.adc_rdy = 1;
        reset = 0;
        #1;
        check("midrst_adc_req", int'(bus.adc_req), 0);
        check("midrst_grant", int'(bus.grant), 0);
        check("midrst_rdy", int'({bus.rdy1, bus.rdy0}), 0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_timeout", int'(bus.timeout_err), 0);
        bus.adc_rdy = 0;
        sb.delete(); last_m = 1; m_dat0 = 0; m_dat1 = 0;
        reset = 1;
        xact(0, 0, 8'hE1, 1, 0, 0, 0, 0);
        xact(0, 0, 8'hE2, 0, 0, 0, 0, 0);
        tick(); tick();
        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_arbiter.md
ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, ADC sample width; TIMEOUT_CYCLES, default 255, watchdog limit in clk cycles.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  requester conversion requests, held high until served.
REQ-005 rdy0, rdy1  output  1 each  one-cycle pulse, sample for that requester valid.
REQ-006 dat0, dat1  output  DATA_W each  last sample delivered to that requester.
REQ-007 adc_req  output  1  conversion request to the shared ADC.
REQ-008 adc_rdy  input  1  ADC conversion-complete flag, synchronous to clk, at least one cycle wide.
REQ-009 adc_dat  input  DATA_W  ADC sample, valid while adc_rdy is high.
REQ-010 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-011 timeout_err  output  1  sticky watchdog flag.

Function
REQ-012 FSM states SHALL be IDLE, CONV and DELIVER.
- IDLE->CONV when any req is high.
- CONV->DELIVER when adc_rdy is sampled high.
- DELIVER->IDLE unconditionally.
REQ-013 Arbitration in IDLE SHALL be round-robin: with one request, grant it; with both, grant the channel not granted last; after reset, channel 0 has priority.
REQ-014 The last-granted pointer SHALL update on every IDLE->CONV transition.
REQ-015 adc_req SHALL be high exactly while in CONV; grant SHALL be valid in CONV and DELIVER.
REQ-016 adc_dat SHALL be captured on the edge adc_rdy is sampled in CONV. In DELIVER, the granted rdyN SHALL pulse for exactly one cycle, with datN equal to the captured value in that cycle.
REQ-017 Latency: req high at edge k gives adc_req at k+1; adc_rdy sampled at edge m gives rdyN high during cycle m+1; the minimum req-to-rdy delay is 2 cycles.
REQ-018 datN SHALL hold its value between deliveries; the non-granted channel's dat/rdy SHALL be unaffected.
REQ-019 If the granted req drops during CONV, the conversion SHALL complete, the data SHALL be discarded (no rdy, dat unchanged) and the FSM SHALL return to IDLE.
- This also applies when the drop coincides with adc_rdy.
REQ-020 adc_rdy outside CONV SHALL be ignored.
REQ-021 A req held high through DELIVER SHALL be re-arbitrated in the next IDLE cycle, with no back-to-back grant when the other channel is requesting.

Reset
REQ-022 On reset low, the following SHALL clear asynchronously:
- state to IDLE;
- adc_req, rdy0, rdy1, timeout_err and grant to 0;
- dat0 and dat1 to 0;
- pointer to favour channel 0;
- watchdog count to 0.
REQ-023 On reset mid-CONV, adc_req SHALL drop immediately and no rdy SHALL issue after release.
REQ-024 Reset deassertion SHALL take effect at the first clk edge after release; there SHALL be no other reset.

Configuration
REQ-025 With ADC_ARB_TIMEOUT_EN defined:
- a watchdog SHALL count CONV cycles;
- on reaching TIMEOUT_CYCLES, it SHALL drop adc_req, set timeout_err (sticky until reset), issue no rdy, advance the pointer and return to IDLE;
- the count SHALL clear on leaving CONV.
REQ-026 Without ADC_ARB_TIMEOUT_EN, CONV SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-027 Package adc_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, CONV=2'd1, DELIVER=2'd2) and the DATA_W default.
REQ-028 Sub-module adc_rr_pick SHALL be combinational: (req0, req1, last) in, one-hot pick out.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Reset, then req0=1; ADC returns 8'hD5 one cycle after adc_req -> rdy0 one-cycle pulse, dat0=8'hD5, grant 01 then 00, rdy1 never high.
- req0=req1=1 held; ADC returns 8'h0A then 8'h99 -> grants alternate 01,10; dat0=8'h0A, dat1=8'h99.
- req1 drops during CONV, ADC returns 8'h9B -> no rdy1, dat1 unchanged, FSM back to IDLE.
- With ADC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, adc_rdy never asserts -> adc_req low after 4 cycles, timeout_err=1 until reset.
- reset pulsed low mid-CONV -> adc_req, grant and rdy* are 0 immediately; after release, req0 is served with channel 0 first.
